vx_commit_arb: RTL and testbench

Merges NUM_REQS commit channels (ALU, LSU, CSR, FPU, GPU…) into a single registered commit stream for writeback/scoreboard release. Round-robin fairness. Grant stays with one channel until its eop beat is accepted, so multi-beat packets are never interleaved. Carries commit performance counters.

---
 rtl/vx_commit_pkg.sv | 37 +++
 rtl/vx_commit_skid.sv | 53 +++++
 rtl/vx_commit_arb.sv | 191 +++++++++++++++++++
 tb/tb_vx_commit_arb.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vx_commit_pkg.sv
// Shared commit-beat type, width constants and popcount helper for the commit arbiter.
package vx_commit_pkg;

  localparam int unsigned CMT_NUM_THREADS = 4;
  localparam int unsigned CMT_DATA_WIDTH  = 32;
  localparam int unsigned CMT_UUID_BITS   = 44;
  localparam int unsigned CMT_NW_BITS     = 2;
  localparam int unsigned CMT_NR_BITS     = 6;
  localparam int unsigned CMT_PC_BITS     = 32;
  localparam int unsigned CMT_LANE_BITS   = CMT_NUM_THREADS * CMT_DATA_WIDTH;
  // Widest thread mask the popcount helper accepts; narrower masks are zero-extended.
  localparam int unsigned CMT_MAX_THREADS = 64;
  localparam int unsigned CMT_POP_BITS    = 7;

  typedef struct packed {
    logic [CMT_UUID_BITS-1:0]   uuid;
    logic [CMT_NW_BITS-1:0]     wid;
    logic [CMT_NUM_THREADS-1:0] tmask;
    logic [CMT_PC_BITS-1:0]     PC;
    logic [CMT_LANE_BITS-1:0]   data;
    logic [CMT_NR_BITS-1:0]     rd;
    logic                       wb;
    logic                       eop;
  } commit_beat_t;

  function automatic logic [CMT_POP_BITS-1:0] popcount_tmask(
    input logic [CMT_MAX_THREADS-1:0] tmask
  );
    logic [CMT_POP_BITS-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < CMT_MAX_THREADS; i++) begin
      cnt = cnt + CMT_POP_BITS'(tmask[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/vx_commit_skid.sv
// Two-entry elastic buffer for commit beats. in_ready comes from the registered
// occupancy only, so it never depends combinationally on out_ready.
module vx_commit_skid
  import vx_commit_pkg::*;
#(
  parameter type beat_t = commit_beat_t
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  in_valid,
  input  beat_t in_beat,
  output logic  in_ready,
  output logic  out_valid,
  output beat_t out_beat,
  input  logic  out_ready
);

  beat_t      mem_q [2];
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] count_q;
  logic       push;
  logic       pop;

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign out_beat  = mem_q[rd_ptr_q];
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Pointer and occupancy bookkeeping; pop and push in one cycle leave the count unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Payload storage; no reset needed since out_beat is ignored while empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_beat;
  end

endmodule

// File: rtl/vx_commit_arb.sv
// Round-robin commit arbiter: merges NUM_REQS commit channels into one registered
// stream, holding the grant on a channel until its eop beat is accepted.
module vx_commit_arb
  import vx_commit_pkg::*;
#(
  parameter int unsigned NUM_REQS    = 4,
  parameter int unsigned NUM_THREADS = CMT_NUM_THREADS,
  parameter int unsigned DATA_WIDTH  = CMT_DATA_WIDTH,
  parameter int unsigned UUID_BITS   = CMT_UUID_BITS,
  parameter int unsigned NW_BITS     = CMT_NW_BITS,
  parameter int unsigned NR_BITS     = CMT_NR_BITS,
  parameter bit          PERF_ENABLE = 1'b1
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [NUM_REQS-1:0]                      in_valid,
  input  logic [NUM_REQS*UUID_BITS-1:0]            in_uuid,
  input  logic [NUM_REQS*NW_BITS-1:0]              in_wid,
  input  logic [NUM_REQS*NUM_THREADS-1:0]          in_tmask,
  input  logic [NUM_REQS*32-1:0]                   in_PC,
  input  logic [NUM_REQS*NUM_THREADS*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_REQS*NR_BITS-1:0]              in_rd,
  input  logic [NUM_REQS-1:0]                      in_wb,
  input  logic [NUM_REQS-1:0]                      in_eop,
  output logic [NUM_REQS-1:0]                      in_ready,
  output logic                                     out_valid,
  output logic [UUID_BITS-1:0]                     out_uuid,
  output logic [NW_BITS-1:0]                       out_wid,
  output logic [NUM_THREADS-1:0]                   out_tmask,
  output logic [31:0]                              out_PC,
  output logic [NUM_THREADS*DATA_WIDTH-1:0]        out_data,
  output logic [NR_BITS-1:0]                       out_rd,
  output logic                                     out_wb,
  output logic                                     out_eop,
  input  logic                                     out_ready,
  output logic [63:0]                              perf_commits,
  output logic [63:0]                              perf_threads
);

  localparam int unsigned IDX_W  = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
  localparam int unsigned LANE_W = NUM_THREADS * DATA_WIDTH;

  typedef struct packed {
    logic [UUID_BITS-1:0]   uuid;
    logic [NW_BITS-1:0]     wid;
    logic [NUM_THREADS-1:0] tmask;
    logic [31:0]            PC;
    logic [LANE_W-1:0]      data;
    logic [NR_BITS-1:0]     rd;
    logic                   wb;
    logic                   eop;
  } beat_t;

  logic [IDX_W-1:0] rr_q;
  logic [IDX_W-1:0] lock_idx_q;
  logic             lock_q;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_valid;
  logic             found;
  int unsigned      cand;
  int unsigned      gsel;
  beat_t            sel_beat;
  logic             push_valid;
  logic             skid_ready;
  logic             accepted;
  beat_t            out_beat;

  // Grant: the locked channel while a packet is open, else first valid from rr_q with wrap.
  always_comb begin
    found       = 1'b0;
    cand        = 0;
    grant_idx   = lock_idx_q;
    grant_valid = lock_q;
    if (!lock_q) begin
      for (int unsigned k = 0; k < NUM_REQS; k++) begin
        cand = (32'(rr_q) + k) % NUM_REQS;
        if (!found && in_valid[IDX_W'(cand)]) begin
          found     = 1'b1;
          grant_idx = IDX_W'(cand);
        end
      end
      grant_valid = found;
    end
  end

  // Payload mux from the granted channel.
  always_comb begin
    gsel           = 32'(grant_idx);
    sel_beat.uuid  = in_uuid[gsel*UUID_BITS +: UUID_BITS];
    sel_beat.wid   = in_wid[gsel*NW_BITS +: NW_BITS];
    sel_beat.tmask = in_tmask[gsel*NUM_THREADS +: NUM_THREADS];
    sel_beat.PC    = in_PC[gsel*32 +: 32];
    sel_beat.data  = in_data[gsel*LANE_W +: LANE_W];
    sel_beat.rd    = in_rd[gsel*NR_BITS +: NR_BITS];
    sel_beat.wb    = in_wb[grant_idx];
    sel_beat.eop   = in_eop[grant_idx];
  end

  // Only the granted channel sees ready, and only when the buffer has room.
  always_comb begin
    in_ready = '0;
    if (grant_valid && skid_ready) in_ready[grant_idx] = 1'b1;
  end

  assign push_valid = grant_valid & in_valid[grant_idx];
  assign accepted   = push_valid & skid_ready;

  // Round-robin pointer and packet lock.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else if (accepted) begin
      if (sel_beat.eop) begin
        lock_q <= 1'b0;
        rr_q   <= (32'(grant_idx) == NUM_REQS - 1) ? '0 : grant_idx + IDX_W'(1);
      end else begin
        lock_q     <= 1'b1;
        lock_idx_q <= grant_idx;
      end
    end
  end

  vx_commit_skid #(
    .beat_t(beat_t)
  ) u_skid (
    .clk      (clk),
    .reset    (reset),
    .in_valid (push_valid),
    .in_beat  (sel_beat),
    .in_ready (skid_ready),
    .out_valid(out_valid),
    .out_beat (out_beat),
    .out_ready(out_ready)
  );

  assign out_uuid  = out_beat.uuid;
  assign out_wid   = out_beat.wid;
  assign out_tmask = out_beat.tmask;
  assign out_PC    = out_beat.PC;
  assign out_data  = out_beat.data;
  assign out_rd    = out_beat.rd;
  assign out_wb    = out_beat.wb;
  assign out_eop   = out_beat.eop;

  generate
    if (PERF_ENABLE) begin : g_perf
      logic [63:0] commits_q;
      logic [63:0] threads_q;
      logic        fire_eop;
      assign fire_eop = out_valid & out_ready & out_beat.eop;
      // Commit counters advance on every eop beat leaving the arbiter.
      always_ff @(posedge clk) begin
        if (reset) begin
          commits_q <= '0;
          threads_q <= '0;
        end else if (fire_eop) begin
          commits_q <= commits_q + 64'd1;
          threads_q <= threads_q
                       + 64'(popcount_tmask(CMT_MAX_THREADS'(out_beat.tmask)));
        end
      end
      assign perf_commits = commits_q;
      assign perf_threads = threads_q;
    end else begin : g_no_perf
      assign perf_commits = '0;
      assign perf_threads = '0;
    end
  endgenerate

`ifndef SYNTHESIS
  logic [UUID_BITS-1:0] pkt_uuid_q;
  logic [NW_BITS-1:0]   pkt_wid_q;

  // Remember the identity of the first beat of each packet.
  always_ff @(posedge clk) begin
    if (accepted && !lock_q) begin
      pkt_uuid_q <= sel_beat.uuid;
      pkt_wid_q  <= sel_beat.wid;
    end
  end

  a_lock_stable : assert property (@(posedge clk) disable iff (reset)
    (lock_q && accepted) |-> (sel_beat.uuid == pkt_uuid_q && sel_beat.wid == pkt_wid_q));

  a_tmask_nonzero : assert property (@(posedge clk) disable iff (reset)
    out_valid |-> (out_tmask != '0));
`endif

endmodule

// File: tb/tb_vx_commit_arb.sv
// Bench for vx_commit_arb: directed vector table, hand-written corner sequences and
// randomized traffic, all checked against a queue-based reference model.
module tb_vx_commit_arb;

  localparam int NR  = 4;
  localparam int NT  = 4;
  localparam int DW  = 32;
  localparam int UB  = 44;
  localparam int NWB = 2;
  localparam int NRB = 6;

  typedef struct packed {
    logic [UB-1:0]    uuid;
    logic [NWB-1:0]   wid;
    logic [NT-1:0]    tmask;
    logic [31:0]      pc;
    logic [NT*DW-1:0] data;
    logic [NRB-1:0]   rd;
    logic             wb;
    logic             eop;
  } beat_t;

  typedef struct packed {
    logic [NR-1:0] valid;
    logic [NR-1:0] eop;
    logic [NR-1:0] exp_ready;
    logic          exp_ovalid;
  } vec_t;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic [NR-1:0]       v = '0;
  beat_t               chb [NR];
  logic                out_ready = 1'b1;

  logic [NR-1:0]       in_valid;
  logic [NR*UB-1:0]    in_uuid;
  logic [NR*NWB-1:0]   in_wid;
  logic [NR*NT-1:0]    in_tmask;
  logic [NR*32-1:0]    in_PC;
  logic [NR*NT*DW-1:0] in_data;
  logic [NR*NRB-1:0]   in_rd;
  logic [NR-1:0]       in_wb;
  logic [NR-1:0]       in_eop;
  logic [NR-1:0]       in_ready;
  logic                out_valid;
  logic [UB-1:0]       out_uuid;
  logic [NWB-1:0]      out_wid;
  logic [NT-1:0]       out_tmask;
  logic [31:0]         out_PC;
  logic [NT*DW-1:0]    out_data;
  logic [NRB-1:0]      out_rd;
  logic                out_wb;
  logic                out_eop;
  logic [63:0]         perf_commits;
  logic [63:0]         perf_threads;

  // Reference model state.
  beat_t       q[$];
  int          rr;
  int          lock_ch;
  bit          locked;
  logic [63:0] m_commits;
  logic [63:0] m_threads;
  logic [NR-1:0] acc;
  logic [NR-1:0] in_pkt;

  int   total = 0;
  int   bad = 0;
  vec_t tbl [20];

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NR; i++) begin
      in_valid[i]               = v[i];
      in_uuid[i*UB +: UB]       = chb[i].uuid;
      in_wid[i*NWB +: NWB]      = chb[i].wid;
      in_tmask[i*NT +: NT]      = chb[i].tmask;
      in_PC[i*32 +: 32]         = chb[i].pc;
      in_data[i*NT*DW +: NT*DW] = chb[i].data;
      in_rd[i*NRB +: NRB]       = chb[i].rd;
      in_wb[i]                  = chb[i].wb;
      in_eop[i]                 = chb[i].eop;
    end
  end

  vx_commit_arb #(
    .NUM_REQS   (NR),
    .NUM_THREADS(NT),
    .DATA_WIDTH (DW),
    .UUID_BITS  (UB),
    .NW_BITS    (NWB),
    .NR_BITS    (NRB),
    .PERF_ENABLE(1'b1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_uuid     (in_uuid),
    .in_wid      (in_wid),
    .in_tmask    (in_tmask),
    .in_PC       (in_PC),
    .in_data     (in_data),
    .in_rd       (in_rd),
    .in_wb       (in_wb),
    .in_eop      (in_eop),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_uuid    (out_uuid),
    .out_wid     (out_wid),
    .out_tmask   (out_tmask),
    .out_PC      (out_PC),
    .out_data    (out_data),
    .out_rd      (out_rd),
    .out_wb      (out_wb),
    .out_eop     (out_eop),
    .out_ready   (out_ready),
    .perf_commits(perf_commits),
    .perf_threads(perf_threads)
  );

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    rr        = 0;
    lock_ch   = 0;
    locked    = 0;
    m_commits = '0;
    m_threads = '0;
    in_pkt    = '0;
    acc       = '0;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    v         = '0;
    out_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  // One clock: compare DUT against the model before the edge, advance the model at the edge.
  task automatic step(input logic [NR-1:0] xr, input logic xo, input bit xchk);
    int            g;
    bit            any;
    bit            pop;
    bit            push;
    logic [NR-1:0] er;
    beat_t         got;
    beat_t         pb;
    @(negedge clk);
    acc = '0;
    any = 0;
    g   = 0;
    if (locked) begin
      any = 1;
      g   = lock_ch;
    end else begin
      for (int k = 0; k < NR; k++) begin
        if (!any && v[(rr + k) % NR]) begin
          any = 1;
          g   = (rr + k) % NR;
        end
      end
    end
    er = '0;
    if (any && q.size() < 2) er[g] = 1'b1;
    chk("in_ready", 256'(in_ready), 256'(er));
    chk("out_valid", 256'(out_valid), 256'(q.size() > 0));
    if (q.size() > 0) begin
      got = '{uuid: out_uuid, wid: out_wid, tmask: out_tmask, pc: out_PC, data: out_data,
              rd: out_rd, wb: out_wb, eop: out_eop};
      chk("out_beat", 256'(got), 256'(q[0]));
    end
    chk("perf_commits", 256'(perf_commits), 256'(m_commits));
    chk("perf_threads", 256'(perf_threads), 256'(m_threads));
    if (xchk) begin
      chk("tbl_in_ready", 256'(in_ready), 256'(xr));
      chk("tbl_out_valid", 256'(out_valid), 256'(xo));
    end
    pop  = (q.size() > 0) && out_ready;
    push = any && er[g] && v[g];
    pb   = chb[g];
    @(posedge clk);
    if (pop) begin
      if (q[0].eop) begin
        m_commits = m_commits + 64'd1;
        m_threads = m_threads + 64'($countones(q[0].tmask));
      end
      void'(q.pop_front());
    end
    if (push) begin
      q.push_back(pb);
      acc[g] = 1'b1;
      if (pb.eop) begin
        locked = 0;
        rr     = (g + 1) % NR;
      end else begin
        locked  = 1;
        lock_ch = g;
      end
    end
    #1;
  endtask

  // Directed payload: uuid/wid fixed per channel so packets keep a stable identity.
  task automatic set_dir(input logic [NR-1:0] vv, input logic [NR-1:0] ee);
    for (int c = 0; c < NR; c++) begin
      v[c]           = vv[c];
      chb[c].uuid    = UB'(44'h0A0 + c);
      chb[c].wid     = NWB'(c);
      chb[c].tmask   = NT'($urandom_range(1, 15));
      chb[c].pc      = $urandom;
      chb[c].data    = {$urandom, $urandom, $urandom, $urandom};
      chb[c].rd      = NRB'($urandom);
      chb[c].wb      = 1'($urandom);
      chb[c].eop     = ee[c];
    end
  endtask

  task automatic new_beat(input int c);
    if (!in_pkt[c]) begin
      chb[c].uuid = {12'($urandom), $urandom};
      chb[c].wid  = NWB'($urandom);
    end
    chb[c].tmask = NT'($urandom_range(1, 15));
    chb[c].pc    = $urandom;
    chb[c].data  = {$urandom, $urandom, $urandom, $urandom};
    chb[c].rd    = NRB'($urandom);
    chb[c].wb    = 1'($urandom);
    chb[c].eop   = ($urandom_range(0, 1) == 1);
    v[c]         = 1'b1;
  endtask

  initial begin
    int n;
    tbl = '{
      '{4'b0000, 4'b0000, 4'b0000, 1'b0},
      '{4'b1111, 4'b1111, 4'b0001, 1'b0},
      '{4'b1111, 4'b1111, 4'b0010, 1'b1},
      '{4'b1111, 4'b1111, 4'b0100, 1'b1},
      '{4'b1111, 4'b1111, 4'b1000, 1'b1},
      '{4'b1111, 4'b1111, 4'b0001, 1'b1},
      '{4'b0000, 4'b0000, 4'b0000, 1'b1},
      '{4'b0000, 4'b0000, 4'b0000, 1'b0},
      '{4'b0110, 4'b0100, 4'b0010, 1'b0},
      '{4'b0110, 4'b0100, 4'b0010, 1'b1},
      '{4'b0110, 4'b0110, 4'b0010, 1'b1},
      '{4'b0100, 4'b0100, 4'b0100, 1'b1},
      '{4'b0000, 4'b0000, 4'b0000, 1'b1},
      '{4'b0110, 4'b0100, 4'b0010, 1'b0},
      '{4'b0100, 4'b0100, 4'b0010, 1'b1},
      '{4'b0100, 4'b0100, 4'b0010, 1'b0},
      '{4'b0110, 4'b0110, 4'b0010, 1'b0},
      '{4'b0100, 4'b0100, 4'b0100, 1'b1},
      '{4'b0000, 4'b0000, 4'b0000, 1'b1},
      '{4'b0000, 4'b0000, 4'b0000, 1'b0}
    };
    set_dir('0, '0);
    do_reset();

    // Reset state, round-robin order, packet lock with and without an in_valid gap.
    chk("reset_perf_commits", 256'(perf_commits), 256'(0));
    chk("reset_perf_threads", 256'(perf_threads), 256'(0));
    for (int r = 0; r < 20; r++) begin
      set_dir(tbl[r].valid, tbl[r].eop);
      step(tbl[r].exp_ready, tbl[r].exp_ovalid, 1'b1);
    end

    // Backpressure: two beats fill the buffer, then channel 0 is held off.
    do_reset();
    set_dir(4'b0001, 4'b0001);
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step((k < 2) ? 4'b0001 : 4'b0000, (k > 0), 1'b1);
      if (acc[0]) set_dir(4'b0001, 4'b0001);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step('0, 1'b0, 1'b0);
      if (acc[0]) set_dir(4'b0001, 4'b0001);
    end
    set_dir('0, '0);
    for (int k = 0; k < 3; k++) step('0, 1'b0, 1'b0);
    chk("stall_drained", 256'(out_valid), 256'(0));

    // Counters: ten eop beats with tmask 1011.
    do_reset();
    set_dir(4'b0001, 4'b0001);
    chb[0].tmask = 4'b1011;
    n = 0;
    for (int c = 0; c < 40 && n < 10; c++) begin
      step('0, 1'b0, 1'b0);
      if (acc[0]) begin
        n++;
        set_dir((n < 10) ? 4'b0001 : 4'b0000, 4'b0001);
        chb[0].tmask = 4'b1011;
      end
    end
    for (int k = 0; k < 3; k++) step('0, 1'b0, 1'b0);
    chk("perf_commits_10", 256'(perf_commits), 256'(10));
    chk("perf_threads_30", 256'(perf_threads), 256'(30));

    // Reset while channel 3 holds the lock mid-packet.
    do_reset();
    set_dir(4'b1000, 4'b0000);
    step(4'b1000, 1'b0, 1'b1);
    set_dir(4'b1000, 4'b0000);
    step(4'b1000, 1'b1, 1'b1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    chk("midreset_out_valid", 256'(out_valid), 256'(0));
    set_dir(4'b1111, 4'b1111);
    #1;
    chk("midreset_grant0", 256'(in_ready), 256'(4'b0001));
    step(4'b0001, 1'b0, 1'b1);

    // Randomized traffic against the model.
    set_dir('0, '0);
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int c = 0; c < NR; c++) begin
        if (acc[c]) begin
          in_pkt[c] = !chb[c].eop;
          v[c]      = 1'b0;
        end
        if (!v[c] && $urandom_range(0, 2) != 0) new_beat(c);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      step('0, 1'b0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
